// File: rtl/spi_reg_pkg.sv
// Shared constants and state encoding for the SPI-to-register-bus bridge.
package spi_reg_pkg;

  localparam int CMD_RD_BIT     = 7;
  localparam int BYTES_PER_WORD = 4;
  localparam int DATA_W         = 8 * BYTES_PER_WORD;

  // Data bytes arrive most-significant lane first.
  localparam logic [1:0] LANE_FIRST = 2'd3;
  localparam logic [1:0] LANE_LAST  = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR,
    ST_RD
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin with registered
// single-cycle rise/fall pulses taken from the last two stages.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 3
) (
  input  logic busClk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rise_reg;
  logic                   fall_reg;

  always_ff @(posedge busClk) begin
    if (reset) begin
      sync_reg <= '0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      rise_reg <= sync_reg[SYNC_STAGES-2] & ~sync_reg[SYNC_STAGES-1];
      fall_reg <= ~sync_reg[SYNC_STAGES-2] & sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = rise_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns command/data frames into byte-lane register
// bus writes and single-cycle register reads returned on MISO.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 3
) (
  input  logic              busClk,
  input  logic              reset,
  input  logic              spiSclk,
  input  logic              spiCsn,
  input  logic              spiMosi,
  output logic              spiMiso,
  output logic              spiMisoEn,
  output logic              cs,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dataIn,
  output logic              wr0,
  output logic              wr1,
  output logic              wr2,
  output logic              wr3,
  input  logic [DATA_W-1:0] dataOut
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic csn_s, csn_rise, csn_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .busClk (busClk),
    .reset  (reset),
    .din    (spiSclk),
    .level  (sclk_s),
    .rise   (sclk_rise),
    .fall   (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_csn_sync (
    .busClk (busClk),
    .reset  (reset),
    .din    (spiCsn),
    .level  (csn_s),
    .rise   (csn_rise),
    .fall   (csn_fall)
  );

  always_ff @(posedge busClk) begin
    if (reset) mosi_sync_reg <= '0;
    else       mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spiMosi};
  end
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  state_t              state_reg;
  logic [2:0]          bit_cnt_reg;
  logic [1:0]          byte_idx_reg;
  logic [6:0]          shift_reg;
  logic [7:0]          shift_next;
  logic [DATA_W-1:0]   miso_shift_reg;
  logic                rd_load_reg;
  logic                skip_fall_reg;
  logic                wr_done_reg;
  logic                cs_reg;
  logic [3:0]          wr_reg;
  logic                miso_en_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   data_in_reg;

  assign shift_next = {shift_reg, mosi_s};

  always_ff @(posedge busClk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= '0;
      byte_idx_reg   <= LANE_FIRST;
      shift_reg      <= '0;
      miso_shift_reg <= '0;
      rd_load_reg    <= 1'b0;
      skip_fall_reg  <= 1'b0;
      wr_done_reg    <= 1'b0;
      cs_reg         <= 1'b0;
      wr_reg         <= '0;
      miso_en_reg    <= 1'b0;
      addr_reg       <= '0;
      data_in_reg    <= '0;
    end else begin
      cs_reg <= 1'b0;
      wr_reg <= '0;
      if (csn_s) begin
        // Frame end or abort: partial bytes are simply dropped.
        state_reg     <= ST_IDLE;
        bit_cnt_reg   <= '0;
        rd_load_reg   <= 1'b0;
        skip_fall_reg <= 1'b0;
        miso_en_reg   <= 1'b0;
        if (csn_rise) miso_shift_reg <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            // A frame starts only on a fresh csn fall with sclk at its mode-0 idle level.
            if (csn_fall && !sclk_s) begin
              state_reg   <= ST_CMD;
              bit_cnt_reg <= '0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              shift_reg   <= shift_next[6:0];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                addr_reg <= shift_next[ADDR_W-1:0];
                if (shift_next[CMD_RD_BIT]) begin
                  state_reg     <= ST_RD;
                  cs_reg        <= 1'b1;
                  rd_load_reg   <= 1'b1;
                  skip_fall_reg <= 1'b1;
                  miso_en_reg   <= 1'b1;
                end else begin
                  state_reg    <= ST_WR;
                  byte_idx_reg <= LANE_FIRST;
                  wr_done_reg  <= 1'b0;
                end
              end
            end
          end
          ST_WR: begin
            if (sclk_rise && !wr_done_reg) begin
              shift_reg   <= shift_next[6:0];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                data_in_reg[{byte_idx_reg, 3'b000} +: 8] <= shift_next;
                cs_reg               <= 1'b1;
                wr_reg[byte_idx_reg] <= 1'b1;
                if (byte_idx_reg == LANE_LAST) wr_done_reg  <= 1'b1;
                else                           byte_idx_reg <= byte_idx_reg - 2'd1;
              end
            end
          end
          ST_RD: begin
            // dataOut is valid during the cs cycle, so capture at its end.
            if (rd_load_reg) begin
              miso_shift_reg <= dataOut;
              rd_load_reg    <= 1'b0;
            end else if (sclk_fall) begin
              // The fall closing the command byte launches bit 31 rather than shifting.
              if (skip_fall_reg) skip_fall_reg  <= 1'b0;
              else               miso_shift_reg <= {miso_shift_reg[DATA_W-2:0], 1'b0};
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign spiMiso   = miso_shift_reg[DATA_W-1];
  assign spiMisoEn = miso_en_reg;
  assign cs        = cs_reg;
  assign addr      = addr_reg;
  assign dataIn    = data_in_reg;
  assign wr0       = wr_reg[0];
  assign wr1       = wr_reg[1];
  assign wr2       = wr_reg[2];
  assign wr3       = wr_reg[3];

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench: an SPI host model drives frames at busClk/8 and a bus
// monitor pops the expected register-bus transactions.
module tb_spi_reg_bridge;

  localparam int ADDR_W      = 5;
  localparam int SYNC_STAGES = 3;
  localparam int HALF        = 40;

  typedef struct packed {
    logic [3:0] wr;
    int         lane;
    logic [7:0] data;
    logic [4:0] addr;
  } ev_t;

  logic              busClk = 1'b0;
  logic              reset = 1'b1;
  logic              spiSclk = 1'b0;
  logic              spiCsn = 1'b1;
  logic              spiMosi = 1'b0;
  logic              spiMiso, spiMisoEn, cs;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       dataIn, dataOut;
  logic              wr0, wr1, wr2, wr3;
  logic [31:0]       rd_value = 32'h0;

  int  check_cnt = 0;
  int  err_cnt   = 0;
  ev_t sb[$];

  spi_reg_bridge #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .busClk    (busClk),
    .reset     (reset),
    .spiSclk   (spiSclk),
    .spiCsn    (spiCsn),
    .spiMosi   (spiMosi),
    .spiMiso   (spiMiso),
    .spiMisoEn (spiMisoEn),
    .cs        (cs),
    .addr      (addr),
    .dataIn    (dataIn),
    .wr0       (wr0),
    .wr1       (wr1),
    .wr2       (wr2),
    .wr3       (wr3),
    .dataOut   (dataOut)
  );

  always #5 busClk = ~busClk;

  // Register bank model: read data is only presented while cs is high.
  assign dataOut = cs ? rd_value : 32'h0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_cs"}, cs, 0);
    check_val({tag, "_wr"}, {wr3, wr2, wr1, wr0}, 0);
    check_val({tag, "_addr"}, addr, 0);
    check_val({tag, "_datain"}, dataIn, 0);
    check_val({tag, "_miso"}, spiMiso, 0);
    check_val({tag, "_misoen"}, spiMisoEn, 0);
  endtask

  // Bus monitor: every cs cycle must match the next expected transaction.
  always @(negedge busClk) begin
    if (!reset && cs) begin
      if (sb.size() == 0) begin
        check_val("unexpected_cs", {wr3, wr2, wr1, wr0, 27'h0, addr}, 64'hFFFF_FFFF);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check_val("wr_strobes", {wr3, wr2, wr1, wr0}, e.wr);
        check_val("addr", addr, e.addr);
        if (e.wr != 4'b0) check_val("lane_data", (dataIn >> (8 * e.lane)) & 32'hFF, e.data);
        $display("bus %s addr=0x%02h wr=%b dataIn=0x%08h", (e.wr == 0) ? "rd" : "wr",
                 addr, {wr3, wr2, wr1, wr0}, dataIn);
      end
    end
  end

  // One SPI frame: 8 command bits then ndata data bits; reset_at>0 pulses reset after that sclk.
  task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] wdata, input int ndata,
                           input int phase, input int gap, input int reset_at);
    logic [63:0] rdata;
    logic [63:0] rexp;
    int          nbytes;
    ev_t         e;
    rdata = '0;
    if (cmd[7]) begin
      e.wr = 4'b0; e.lane = 0; e.data = 8'h0; e.addr = cmd[4:0];
      sb.push_back(e);
    end else begin
      nbytes = (ndata / 8 > 4) ? 4 : ndata / 8;
      for (int k = 0; k < nbytes; k++) begin
        if (reset_at == 0 || 16 + 8 * k <= reset_at) begin
          e.lane = 3 - k;
          e.wr   = 4'b0001 << (3 - k);
          e.data = wdata[8 * (3 - k) +: 8];
          e.addr = cmd[4:0];
          sb.push_back(e);
        end
      end
    end
    @(posedge busClk);
    #(phase);
    spiCsn = 1'b0;
    for (int i = 0; i < 8 + ndata; i++) begin
      if (i < 8)       spiMosi = cmd[7 - i];
      else if (i < 40) spiMosi = wdata[39 - i];
      else             spiMosi = 1'($urandom_range(0, 1));
      #(HALF);
      if (i >= 8) rdata = {rdata[62:0], spiMiso};
      if (i == 20 && reset_at == 0) check_val(cmd[7] ? "misoen_rd" : "misoen_wr", spiMisoEn, cmd[7]);
      spiSclk = 1'b1;
      if (reset_at == i + 1) begin
        fork
          begin
            @(posedge busClk); #1 reset = 1'b1;
            @(posedge busClk); #1 check_outputs_zero("reset_mid");
            @(posedge busClk); #1 reset = 1'b0;
          end
        join_none
      end
      #(HALF);
      spiSclk = 1'b0;
    end
    #(HALF);
    spiCsn = 1'b1;
    #(gap);
    check_val("misoen_after", spiMisoEn, 0);
    if (cmd[7]) begin
      rexp = {rd_value, 32'h0} >> (64 - ndata);
      check_val("rd_data", rdata, rexp);
    end
    $display("frame cmd=0x%02h ndata=%0d phase=%0d rdata=0x%0h", cmd, ndata, phase, rdata);
  endtask

  initial begin
    logic [7:0]  cmd;
    logic [31:0] wd;
    int          nd;
    repeat (3) @(negedge busClk);
    check_outputs_zero("reset");
    @(posedge busClk); #1 reset = 1'b0;
    #200;

    spi_frame(8'h04, 32'hDEADBEEF, 32, 3, 100, 0);

    rd_value = 32'hF1234567;
    spi_frame(8'h80, 32'h0, 32, 7, 100, 0);

    // Clock past the 32 data bits: MISO must then read zeros.
    rd_value = 32'hA5C3_0F96;
    spi_frame(8'h9F, 32'h0, 36, 5, 100, 0);

    spi_frame(8'h10, 32'h1234_A5A5, 19, 2, 100, 0);

    spi_frame(8'h05, 32'hCAFEF00D, 32, 4, 100, 20);
    spi_frame(8'h06, 32'h0102_0304, 32, 6, 100, 0);

    rd_value = 32'h8BAD_F00D;
    spi_frame(8'h83, 32'h0, 32, 1, 50, 0);
    spi_frame(8'h07, 32'h5566_7788, 32, 9, 50, 0);
    rd_value = 32'h0000_0001;
    spi_frame(8'h9E, 32'h0, 32, 8, 50, 0);

    for (int n = 0; n < 150; n++) begin
      cmd = 8'($urandom_range(0, 255));
      wd  = $urandom;
      if (cmd[7]) begin
        rd_value = $urandom;
        nd = 32 + $urandom_range(0, 8);
      end else begin
        nd = $urandom_range(0, 40);
      end
      spi_frame(cmd, wd, nd, $urandom_range(1, 9), 50 + 10 * $urandom_range(0, 5), 0);
    end

    repeat (20) @(negedge busClk);
    check_val("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
